load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/load_store_align.sv | 56 +++++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory load/store path: access sizes,
// load/store FSM states and the default memory depth.
package mips_mem_pkg;

   localparam int unsigned MEM_WORDS_DEFAULT = 128;

   typedef logic [1:0] size_t;
   localparam size_t SIZE_BYTE    = 2'b00;
   localparam size_t SIZE_HALF    = 2'b01;
   localparam size_t SIZE_WORD    = 2'b10;
   localparam size_t SIZE_ILLEGAL = 2'b11;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_MERGE = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/load_store_align.sv
// Little-endian lane handling: extracts and extends a load lane, and merges
// sub-word store data into the current memory word.
module load_store_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merge_data_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata_i[7:0];
      case (offset_i)
         2'd0:    byte_lane = rdata_i[7:0];
         2'd1:    byte_lane = rdata_i[15:8];
         2'd2:    byte_lane = rdata_i[23:16];
         default: byte_lane = rdata_i[31:24];
      endcase
      half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      load_data_o = rdata_i;
      case (size_i)
         SIZE_BYTE: load_data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
         SIZE_HALF: load_data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
         default:   load_data_o = rdata_i;
      endcase
   end

   always_comb begin
      merge_data_o = rdata_i;
      case (size_i)
         SIZE_BYTE: begin
            case (offset_i)
               2'd0:    merge_data_o[7:0]   = wdata_i[7:0];
               2'd1:    merge_data_o[15:8]  = wdata_i[7:0];
               2'd2:    merge_data_o[23:16] = wdata_i[7:0];
               default: merge_data_o[31:24] = wdata_i[7:0];
            endcase
         end
         SIZE_HALF: begin
            if (offset_i[1]) merge_data_o[31:16] = wdata_i[15:0];
            else             merge_data_o[15:0]  = wdata_i[15:0];
         end
         SIZE_WORD: merge_data_o = wdata_i;
         default:   merge_data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit between the CPU and a word-wide data memory
// with combinational reads; sub-word stores use read-merge-write.
module load_store_unit
   import mips_mem_pkg::*;
#(
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_addr,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   logic [2:0]  state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_write_q, mem_write_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_error_q, resp_error_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic        req_err;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   // mem_wdata_q still holds the raw store data while in MERGE
   load_store_align u_align (
      .size_i      (size_q),
      .unsigned_i  (uns_q),
      .offset_i    (off_q),
      .rdata_i     (mem_rdata),
      .wdata_i     (mem_wdata_q),
      .load_data_o (load_data),
      .merge_data_o(merge_data)
   );

   always_comb begin
      req_err = (req_size == SIZE_ILLEGAL)
              || ((req_size == SIZE_HALF) && req_addr[0])
              || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
              || ({2'b00, req_addr[31:2]} >= MEM_WORDS);
   end

   always_comb begin
      state_d      = state_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_write_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_error_d = resp_error_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               size_d       = req_size;
               uns_d        = req_unsigned;
               off_d        = req_addr[1:0];
               mem_addr_d   = {2'b00, req_addr[31:2]};
               mem_wdata_d  = req_wdata;
               resp_rdata_d = 32'h0;
               resp_error_d = req_err;
               if (req_err) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
               end else if (!req_write) begin
                  state_d = ST_LOAD;
               end else if (req_size == SIZE_WORD) begin
                  state_d     = ST_WRITE;
                  mem_write_d = 1'b1;
               end else begin
                  state_d = ST_MERGE;
               end
            end
         end
         ST_LOAD: begin
            resp_rdata_d = load_data;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
         end
         ST_MERGE: begin
            mem_wdata_d = merge_data;
            mem_write_d = 1'b1;
            state_d     = ST_WRITE;
         end
         ST_WRITE: begin
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         size_q       <= SIZE_BYTE;
         uns_q        <= 1'b0;
         off_q        <= 2'b00;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_write_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         off_q        <= off_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_write_q  <= mem_write_d;
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_error = resp_error_q;
   assign mem_addr   = mem_addr_q;
   assign mem_write  = mem_write_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
